toggle_monitor: RTL and testbench

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

---
 rtl/toggle_monitor.sv | 97 +++++++++
 tb/tb_toggle_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_monitor.sv
// toggle_monitor: counts toggles of an upstream T flip-flop output with saturation,
// and detects a 4-bit serial pattern (overlapping) in the sampled stream.
module toggle_monitor #(
  parameter int         CNT_W   = 8,
  parameter logic [3:0] PATTERN = 4'b1011
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Q,
  input  logic             Clr,
  output logic [CNT_W-1:0] Count,
  output logic             Sat,
  output logic             Edge,
  output logic             Match
);

  // State value equals the length of the pattern prefix matched so far.
  typedef enum logic [1:0] {S0, S1, S10, S101} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       q_s;
  logic       q_p;
  state_t     state;
  state_t     state_next;
  logic       match_next;
  logic [2:0] step;

  // One KMP step: {hit, next prefix length}. On a full match, fall back to the
  // longest proper border of PATTERN so overlapping occurrences are found.
  function automatic logic [2:0] kmp_step(input logic [1:0] k, input logic b);
    int   pat;
    int   seen;
    int   best;
    logic hit;
    pat  = int'(PATTERN);
    seen = ((pat >> (4 - int'(k))) << 1) | int'(b);
    best = 0;
    hit  = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j <= int'(k) + 1 && (seen & ((1 << j) - 1)) == (pat >> (4 - j)))
        best = j;
    end
    if (best == 4) begin
      hit  = 1'b1;
      best = 0;
      for (int j = 1; j <= 3; j++) begin
        if ((pat & ((1 << j) - 1)) == (pat >> (4 - j)))
          best = j;
      end
    end
    return {hit, best[1:0]};
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_s <= 1'b0;
      q_p <= 1'b0;
    end else begin
      q_s <= Q;
      q_p <= q_s;
    end
  end

  assign Edge = q_s ^ q_p;

  // Clear has priority over a simultaneous toggle; the count never wraps.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Count <= '0;
      Sat   <= 1'b0;
    end else if (Clr) begin
      Count <= '0;
      Sat   <= 1'b0;
    end else if (Edge && Count != CNT_MAX) begin
      Count <= Count + 1'b1;
      Sat   <= (Count + 1'b1) == CNT_MAX;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S0;
      Match <= 1'b0;
    end else begin
      state <= state_next;
      Match <= match_next;
    end
  end

  always_comb begin
    step       = kmp_step(state, q_s);
    state_next = state_t'(step[1:0]);
    match_next = step[2];
  end

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: directed stimulus pushes expected Edge/Match events into
// queues; a negedge monitor pops and compares whenever the DUT pulses.
module tb_toggle_monitor;

  typedef struct {
    int   cyc;
    int   cnt;
    int   cnt3;
    logic sat3;
  } edgeExp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Q   = 1'b0;
  logic       Clr = 1'b0;
  logic [7:0] Count;
  logic       Sat;
  logic       Edge;
  logic       Match;
  logic [2:0] Count3;
  logic       Sat3;
  logic       Edge3;
  logic       Match3;

  int       cyc    = 0;
  int       checks = 0;
  int       fails  = 0;
  edgeExp_t edgeQ[$];
  int       matchQ[$];

  toggle_monitor dut (
    .Clk(Clk), .Rst(Rst), .Q(Q), .Clr(Clr),
    .Count(Count), .Sat(Sat), .Edge(Edge), .Match(Match)
  );

  toggle_monitor #(.CNT_W(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Q(Q), .Clr(Clr),
    .Count(Count3), .Sat(Sat3), .Edge(Edge3), .Match(Match3)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive Q one cycle; Edge appears one cycle later, Match two cycles later.
  task automatic applyStimulus(input logic qVal, input logic expEdge, input logic expMatch,
                               input int eCnt, input int eCnt3, input logic eSat3);
    edgeExp_t e;
    @(posedge Clk);
    #1;
    Q = qVal;
    if (expEdge) begin
      e.cyc  = cyc + 1;
      e.cnt  = eCnt;
      e.cnt3 = eCnt3;
      e.sat3 = eSat3;
      edgeQ.push_back(e);
    end
    if (expMatch) matchQ.push_back(cyc + 2);
  endtask

  task automatic applyReset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    Q   = 1'b0;
    Clr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
  endtask

  task automatic checkDrained(input string name);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    checkOutput({name, "EdgeQueueEmpty"}, edgeQ.size(), 0);
    checkOutput({name, "MatchQueueEmpty"}, matchQ.size(), 0);
  endtask

  // Monitor: every Edge/Match pulse must line up with the head of its queue.
  always @(negedge Clk) begin
    edgeExp_t e;
    int mc;
    if (Edge === 1'b1) begin
      if (edgeQ.size() == 0) begin
        checkOutput("unexpectedEdge", 1, 0);
      end else begin
        e = edgeQ.pop_front();
        checkOutput("edgeCycle", cyc, e.cyc);
        checkOutput("edgeCount", int'(Count), e.cnt);
        checkOutput("edgeSat", int'(Sat), 0);
        checkOutput("edgeCount3", int'(Count3), e.cnt3);
        checkOutput("edgeSat3", int'(Sat3), int'(e.sat3));
      end
    end
    if (Match === 1'b1) begin
      if (matchQ.size() == 0) begin
        checkOutput("unexpectedMatch", 1, 0);
      end else begin
        mc = matchQ.pop_front();
        checkOutput("matchCycle", cyc, mc);
      end
    end
  end

  initial begin
    logic [6:0] patBits;
    logic [6:0] patEdge;
    logic [6:0] patMatch;
    int         cnt3Tab[9];
    logic [8:0] sat3Tab;
    int         eCnt;

    // Reset then idle with Q low: everything stays zero.
    applyReset();
    repeat (10) begin
      @(negedge Clk);
      checkOutput("idleOutputs", int'({Count, Sat, Edge, Match}), 0);
      checkOutput("idleOutputs3", int'({Count3, Sat3, Edge3, Match3}), 0);
    end

    // Five toggles, three cycles apart.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(~Q, 1'b1, 1'b0, i, i, 1'b0);
      repeat (2) @(posedge Clk);
    end
    @(negedge Clk);
    checkOutput("toggleCount", int'(Count), 5);
    checkOutput("toggleSat", int'(Sat), 0);
    checkOutput("toggleCount3", int'(Count3), 5);
    checkDrained("toggle");

    // Clear to zero, count to 4, then clear in the same cycle as an Edge.
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    @(negedge Clk);
    checkOutput("clrCount", int'(Count), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(~Q, 1'b1, 1'b0, i, i, 1'b0);
      repeat (2) @(posedge Clk);
    end
    applyStimulus(~Q, 1'b1, 1'b0, 4, 4, 1'b0);
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    Clr = 1'b0;
    @(negedge Clk);
    checkOutput("clrWinsCount", int'(Count), 0);
    checkOutput("clrWinsCount3", int'(Count3), 0);
    applyStimulus(~Q, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("afterClrCount", int'(Count), 1);
    checkDrained("clr");

    // Nine toggles: the 3-bit instance saturates at 7 from the 7th toggle.
    applyReset();
    cnt3Tab = '{0, 1, 2, 3, 4, 5, 6, 7, 7};
    sat3Tab = 9'b110000000;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(~Q, 1'b1, 1'b0, i, cnt3Tab[i], sat3Tab[i]);
      repeat (2) @(posedge Clk);
    end
    @(negedge Clk);
    checkOutput("satCount", int'(Count), 9);
    checkOutput("satSat", int'(Sat), 0);
    checkOutput("satCount3", int'(Count3), 7);
    checkOutput("satSat3", int'(Sat3), 1);
    checkDrained("sat");

    // Overlapping pattern 1011011: matches after the 4th and 7th bits.
    applyReset();
    patBits  = 7'b1011011;
    patEdge  = 7'b1110110;
    patMatch = 7'b0001001;
    eCnt = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(patBits[6-i], patEdge[6-i], patMatch[6-i], eCnt, eCnt, 1'b0);
      if (patEdge[6-i]) eCnt++;
    end
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    checkOutput("patternCount", int'(Count), 5);
    checkOutput("patternHoldState", int'(dut.state), 1);
    checkDrained("pattern");

    // Bits 1,0,1 then a reset: the following 1 must not complete the pattern.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 2, 1'b0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    edgeQ.push_back('{cyc: cyc + 1, cnt: 0, cnt3: 0, sat3: 1'b0});
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("midResetState", int'(dut.state), 1);
    checkOutput("midResetMatch", int'(Match), 0);
    checkOutput("midResetCount", int'(Count), 1);
    checkDrained("midReset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
